// File: rtl/adc_resp_pkg.sv
// Shared constants, state encoding and config decode for the LTC2308-style SPI responder.
package adc_resp_pkg;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned CFG_W  = 6;
    localparam int unsigned CH_W   = 3;

    localparam int unsigned CFG_SD  = 5;
    localparam int unsigned CFG_OS  = 4;
    localparam int unsigned CFG_S1  = 3;
    localparam int unsigned CFG_S0  = 2;
    localparam int unsigned CFG_UNI = 1;
    localparam int unsigned CFG_SLP = 0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CONV
    } state_e;

    // Single-ended channel map; differential configs reuse the same mapping.
    function automatic logic [CH_W-1:0] ch_from_cfg(input logic [CFG_W-1:0] cfg);
        return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
    endfunction

endpackage

// File: rtl/adc_spi_responder_if.sv
// ADC serial link: controller (master) drives SCLK/CS_N/DIN, responder (slave) drives DOUT.
interface adc_spi_responder_if;

    logic ADC_SCLK;
    logic ADC_CS_N;
    logic ADC_DIN;
    logic ADC_DOUT;

    modport master (
        output ADC_SCLK,
        output ADC_CS_N,
        output ADC_DIN,
        input  ADC_DOUT
    );

    modport slave (
        input  ADC_SCLK,
        input  ADC_CS_N,
        input  ADC_DIN,
        output ADC_DOUT
    );

endinterface

// File: rtl/adc_resp_sync.sv
// Multi-flop synchronizer with a trailing edge-detect flop producing rise/fall pulses.
module adc_resp_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clock,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // No reset: the chain keeps tracking the line so reset release never fakes an edge.
    always_ff @(posedge clock) begin
        sync_q <= STAGES'({sync_q, d_i});
        prev_q <= sync_q[STAGES-1];
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// Loopback responder for an LTC2308-style ADC: captures config, returns last frame's result.
// Optional dither: define ADC_RESP_NOISE_EN to add LFSR noise to each snapshot.
module adc_spi_responder
    import adc_resp_pkg::*;
#(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned CONV_CYCLES = 80,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    adc_spi_responder_if.slave       spi,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     frame_done,
    output logic [CH_W-1:0]          last_channel,
    output logic                     conv_violation
);

    localparam int unsigned CONV_W = $clog2(CONV_CYCLES + 1);
    localparam int unsigned CCNT_W = $clog2(CFG_W + 1);
    localparam int unsigned OCNT_W = $clog2(DATA_W);
    localparam int unsigned SUM_W  = DATA_W + 1;

    logic sclk_rise_c, sclk_fall_c, cs_rise_c, cs_fall_c, din_c;
    logic unused_sclk_lvl, unused_cs_lvl, unused_din_rise, unused_din_fall;

    adc_resp_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clock(clock), .d_i(spi.ADC_SCLK),
        .level_o(unused_sclk_lvl), .rise_o(sclk_rise_c), .fall_o(sclk_fall_c)
    );
    adc_resp_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clock(clock), .d_i(spi.ADC_CS_N),
        .level_o(unused_cs_lvl), .rise_o(cs_rise_c), .fall_o(cs_fall_c)
    );
    adc_resp_sync #(.STAGES(SYNC_STAGES)) u_sync_din (
        .clock(clock), .d_i(spi.ADC_DIN),
        .level_o(din_c), .rise_o(unused_din_rise), .fall_o(unused_din_fall)
    );

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [CFG_W-1:0]    cfg_q, cfg_d;
    logic [CCNT_W-1:0]   cfg_cnt_q, cfg_cnt_d;
    logic [OCNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [CONV_W-1:0]   conv_cnt_q, conv_cnt_d;
    logic [CH_W-1:0]     last_ch_q, last_ch_d;
    logic                uni_q, uni_d;
    logic                dout_q, dout_d;
    logic                frame_done_q, frame_done_d;
    logic                conv_viol_q, conv_viol_d;
    logic [DATA_W-1:0]   sel_c, noisy_c, snap_c;
    logic                unused_cfg_bits;

    // SLP and S/D are captured but carry no behaviour.
    assign unused_cfg_bits = cfg_q[CFG_SD] ^ cfg_q[CFG_SLP];

    assign sel_c = ch_data[DATA_W*32'(last_ch_q) +: DATA_W];

`ifdef ADC_RESP_NOISE_EN
    logic [15:0]      lfsr_q, lfsr_d;
    logic [SUM_W-1:0] sum_c;

    assign sum_c   = SUM_W'(sel_c) + SUM_W'(lfsr_q[1:0]);
    assign noisy_c = sum_c[DATA_W] ? '1 : sum_c[DATA_W-1:0];
`else
    assign noisy_c = sel_c;
`endif

    // Bipolar mode flips the MSB: offset-binary to two's complement.
    assign snap_c = uni_q ? noisy_c : (noisy_c ^ {1'b1, {(DATA_W-1){1'b0}}});

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        result_d     = result_q;
        cfg_d        = cfg_q;
        cfg_cnt_d    = cfg_cnt_q;
        out_cnt_d    = out_cnt_q;
        conv_cnt_d   = conv_cnt_q;
        last_ch_d    = last_ch_q;
        uni_d        = uni_q;
        dout_d       = dout_q;
        frame_done_d = 1'b0;
        conv_viol_d  = 1'b0;
`ifdef ADC_RESP_NOISE_EN
        lfsr_d       = lfsr_q;
`endif
        // Frame start from IDLE, or early start that abandons a pending snapshot.
        if (cs_fall_c && state_q != SHIFT) begin
            conv_viol_d = (state_q == CONV);
            shift_d     = result_q;
            dout_d      = result_q[DATA_W-1];
            cfg_cnt_d   = '0;
            out_cnt_d   = '0;
            state_d     = SHIFT;
        end else begin
            case (state_q)
                SHIFT: begin
                    if (cs_rise_c) begin
                        frame_done_d = 1'b1;
                        if (cfg_cnt_q == CCNT_W'(CFG_W)) begin
                            last_ch_d = ch_from_cfg(cfg_q);
                            uni_d     = cfg_q[CFG_UNI];
                        end
                        conv_cnt_d = CONV_W'(CONV_CYCLES - 1);
                        state_d    = CONV;
                    end else begin
                        if (sclk_rise_c && cfg_cnt_q < CCNT_W'(CFG_W)) begin
                            cfg_d     = {cfg_q[CFG_W-2:0], din_c};
                            cfg_cnt_d = cfg_cnt_q + CCNT_W'(1);
                        end
                        if (sclk_fall_c) begin
                            if (out_cnt_q < OCNT_W'(DATA_W - 1)) begin
                                shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                                dout_d    = shift_q[DATA_W-2];
                                out_cnt_d = out_cnt_q + OCNT_W'(1);
                            end else begin
                                dout_d = 1'b0;
                            end
                        end
                    end
                end
                CONV: begin
                    if (conv_cnt_q == '0) begin
                        result_d = snap_c;
                        state_d  = IDLE;
`ifdef ADC_RESP_NOISE_EN
                        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif
                    end else begin
                        conv_cnt_d = conv_cnt_q - CONV_W'(1);
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            result_q     <= '0;
            cfg_q        <= '0;
            cfg_cnt_q    <= '0;
            out_cnt_q    <= '0;
            conv_cnt_q   <= '0;
            last_ch_q    <= '0;
            uni_q        <= 1'b1;
            dout_q       <= 1'b0;
            frame_done_q <= 1'b0;
            conv_viol_q  <= 1'b0;
`ifdef ADC_RESP_NOISE_EN
            lfsr_q       <= 16'hACE1;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            result_q     <= result_d;
            cfg_q        <= cfg_d;
            cfg_cnt_q    <= cfg_cnt_d;
            out_cnt_q    <= out_cnt_d;
            conv_cnt_q   <= conv_cnt_d;
            last_ch_q    <= last_ch_d;
            uni_q        <= uni_d;
            dout_q       <= dout_d;
            frame_done_q <= frame_done_d;
            conv_viol_q  <= conv_viol_d;
`ifdef ADC_RESP_NOISE_EN
            lfsr_q       <= lfsr_d;
`endif
        end
    end

    assign spi.ADC_DOUT   = dout_q;
    assign frame_done     = frame_done_q;
    assign conv_violation = conv_viol_q;
    assign last_channel   = last_ch_q;

endmodule
